joy_sar_scanner: RTL and testbench
==================================

# joy_sar_scanner

Hardware successive-approximation sequencer for the four joystick axes. It time-shares the 6-bit sound DAC and the SELA/SELB analogue mux with the CPU's PIA outputs, and drives the trial value into the DAC/comparator block. It reads back the registered HILO comparator result and publishes four 6-bit axis positions. It sits between the PIA register outputs and the DAC/comparator block, and scans only while CPU sound is disabled, so conversions are never audible.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- SETTLE, 2, wait cycles between applying a trial value and sampling hilo (min 2: comparator output is registered).
- SCAN_PERIOD, 16384, clk cycles between scan starts.

Ports:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- enable  in  1  scanner enable; 0 = pure pass-through
- snden  in  1  CPU sound enable (PIA); 1 revokes scanner ownership
- cpu_dac  in  6  CPU DAC value
- cpu_sela, cpu_selb  in  1 each  CPU mux selects
- hilo  in  1  comparator result from DAC block (1 = joystick > DAC)
- dac_out  out  6  value to DAC block
- sela_out, selb_out  out  1 each  selects to DAC block
- axis0..axis3  out  6 each  last completed conversion, axis i = {selb,sela}=i
- scan_done  out  1  one-cycle pulse after axis3 result written
- busy  out  1  scanner owns DAC/mux

## Operation
- Ownership: `own` is registered. It is set on leaving IDLE and cleared on return to IDLE. While own=0, dac_out/sel outputs follow cpu_dac/cpu_sel registered (1-cycle latency). While own=1, they carry the SAR trial and axis index.
- Tick counter: free-running 0..SCAN_PERIOD-1 and wraps. Wrap sets `pending`. `pending` is cleared when a scan starts. A wrap during an active scan or abort still leaves pending set; at most one pending.
- FSM states:
  - IDLE: start when pending && enable && !snden. Go to LOAD with axis=0, bit=5, sar=0.
  - LOAD: dac_out <= sar | (1<<bit), sel <= axis. Go to WAIT with cnt=0.
  - WAIT: increment cnt. When cnt==SETTLE-1, sample hilo; on hilo=1 set sar[bit]=1. Then if bit==0 go to STORE, else bit--, LOAD.
  - STORE: axis[axis] <= sar. If axis==3, pulse scan_done and go to IDLE. Else axis++, bit=5, sar=0, go to LOAD.
- Result semantics: bit kept when joystick > trial. Result = joy==0 ? 0 : joy-1 (6-bit joystick value).
- Abort: snden=1 or enable=0 in any non-IDLE state goes to IDLE next cycle. Already-stored axes keep their new values; the aborted axis keeps its old value; no scan_done; pending is unchanged. The next scan restarts at axis0.
- Simultaneous start condition and abort condition: abort wins; stay in IDLE.

## Timing
- Reset values: dac_out=0, sela_out=selb_out=0, axis0..3=0, scan_done=0, busy=0, FSM=IDLE, counter=0, pending=0.
- Per bit: 1 (LOAD) + SETTLE (WAIT) cycles. Per axis: 6*(SETTLE+1)+1 cycles. Full scan: 4*(6*(SETTLE+1)+1) cycles; 76 at SETTLE=2.
- busy rises the cycle after IDLE exits and falls the cycle the FSM reenters IDLE.
- Pass-through resumes on the first cycle with own=0.
- hilo is sampled on the clock edge ending the last WAIT cycle.
- scan_done is asserted in the cycle after the STORE of axis3, concurrent with axis3 update visibility.

## Structure
- Shared package (coco_pkg): FSM state enum (IDLE, LOAD, WAIT, STORE), AXIS_W=6, NUM_AXES=4.
- Single module; no sub-module. Include a behavioural comparator model (registered hilo from per-axis joystick values) in the bench only.

## Test plan
- Reset mid-WAIT of axis1 -> all outputs at reset values next cycle; axis registers 0; busy=0.
- SETTLE=2, snden=0, joysticks {0x2A,0x00,0x3F,0x01} -> after 76 cycles axis0..3 = {0x29,0x00,0x3E,0x00}; one scan_done pulse.
- While scanning, snden rises during axis2 -> busy falls next cycle; dac_out follows cpu_dac 1 cycle later; axis0/1 updated, axis2/3 unchanged; no scan_done.
- enable=0, cpu_dac=0x15, sel=2'b10 -> dac_out=0x15, selb_out=1, sela_out=0 after 1 cycle; no scan ever starts.
- SCAN_PERIOD=32 with snden held 1 for 100 cycles -> exactly one scan starts when snden falls; second scan starts at the next wrap.
- Trial sequence check joy=0x2A axis0 -> dac_out LOAD values 0x20,0x30,0x28,0x2C,0x2A,0x29.

Source files
------------

// File: rtl/coco_pkg.sv
// Shared types and sizes for the joystick successive-approximation scanner.
package coco_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_e;

  localparam int AXIS_W   = 6;
  localparam int NUM_AXES = 4;
endpackage

// File: rtl/joy_sar_scanner.sv
// Time-shares the sound DAC and analogue mux to run 6-bit SAR conversions on
// the four joystick axes whenever CPU sound is off; otherwise passes PIA values through.
module joy_sar_scanner
  import coco_pkg::*;
#(
  parameter int SETTLE      = 2,
  parameter int SCAN_PERIOD = 16384
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              snden,
  input  logic [AXIS_W-1:0] cpu_dac,
  input  logic              cpu_sela,
  input  logic              cpu_selb,
  input  logic              hilo,
  output logic [AXIS_W-1:0] dac_out,
  output logic              sela_out,
  output logic              selb_out,
  output logic [AXIS_W-1:0] axis0,
  output logic [AXIS_W-1:0] axis1,
  output logic [AXIS_W-1:0] axis2,
  output logic [AXIS_W-1:0] axis3,
  output logic              scan_done,
  output logic              busy
);

  localparam int TICK_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int CNT_W  = $clog2(SETTLE + 1);

  state_e              state_q;
  logic                own_q;
  logic [AXIS_W-1:0]   dac_q;
  logic [1:0]          sel_q;
  logic [AXIS_W-1:0]   axis_q [NUM_AXES];
  logic                done_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                pending_q;
  logic [AXIS_W-1:0]   sar_q;
  logic [2:0]          bit_q;
  logic [1:0]          ax_q;
  logic [CNT_W-1:0]    cnt_q;

  logic abort, start, wrap;

  assign abort  = snden | ~enable;
  assign start  = (state_q == IDLE) && pending_q && !abort;
  assign wrap   = (tick_q == TICK_W'(SCAN_PERIOD - 1));
  assign tick_d = wrap ? '0 : tick_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      own_q     <= 1'b0;
      dac_q     <= '0;
      sel_q     <= '0;
      axis_q    <= '{default: '0};
      done_q    <= 1'b0;
      tick_q    <= '0;
      pending_q <= 1'b0;
      sar_q     <= '0;
      bit_q     <= '0;
      ax_q      <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      tick_q <= tick_d;
      // A wrap coinciding with a scan start still leaves one scan queued.
      if (start) pending_q <= 1'b0;
      if (wrap)  pending_q <= 1'b1;
      if (!own_q) begin
        dac_q <= cpu_dac;
        sel_q <= {cpu_selb, cpu_sela};
      end
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= LOAD;
          own_q   <= 1'b1;
          ax_q    <= '0;
          bit_q   <= 3'd5;
          sar_q   <= '0;
        end
      end else if (abort) begin
        // Abort beats any store in flight: the current axis keeps its old value.
        state_q <= IDLE;
        own_q   <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            dac_q   <= sar_q | (AXIS_W'(1) << bit_q);
            sel_q   <= ax_q;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
          WAIT: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SETTLE - 1)) begin
              if (hilo) sar_q[bit_q] <= 1'b1;
              if (bit_q == 3'd0) begin
                state_q <= STORE;
              end else begin
                bit_q   <= bit_q - 1'b1;
                state_q <= LOAD;
              end
            end
          end
          STORE: begin
            axis_q[ax_q] <= sar_q;
            if (ax_q == 2'd3) begin
              done_q  <= 1'b1;
              own_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              ax_q    <= ax_q + 1'b1;
              bit_q   <= 3'd5;
              sar_q   <= '0;
              state_q <= LOAD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dac_out   = dac_q;
  assign sela_out  = sel_q[0];
  assign selb_out  = sel_q[1];
  assign axis0     = axis_q[0];
  assign axis1     = axis_q[1];
  assign axis2     = axis_q[2];
  assign axis3     = axis_q[3];
  assign scan_done = done_q;
  assign busy      = own_q;

endmodule

// File: tb/tb_joy_sar_scanner.sv
// Bench for joy_sar_scanner: comparator model plus a progress-index reference model.
module tb_joy_sar_scanner;
  localparam int SET  = 2;
  localparam int PER  = 32;
  localparam int BITC = SET + 1;
  localparam int AXC  = 6 * BITC + 1;

  logic       clk, reset_n, enable, snden, cpu_sela, cpu_selb, hilo;
  logic [5:0] cpu_dac, dac_out, axis0, axis1, axis2, axis3;
  logic       sela_out, selb_out, scan_done, busy;
  logic [5:0] joy [4];

  joy_sar_scanner #(.SETTLE(SET), .SCAN_PERIOD(PER)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .snden(snden),
    .cpu_dac(cpu_dac), .cpu_sela(cpu_sela), .cpu_selb(cpu_selb), .hilo(hilo),
    .dac_out(dac_out), .sela_out(sela_out), .selb_out(selb_out),
    .axis0(axis0), .axis1(axis1), .axis2(axis2), .axis3(axis3),
    .scan_done(scan_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered comparator: 1 when the selected joystick exceeds the DAC value.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hilo <= 1'b0;
    else          hilo <= joy[{selb_out, sela_out}] > dac_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: scan progress index p counts cycles since scan start.
  int m_busy, m_p, m_tick, m_pend, m_done, m_dac, m_sel;
  int m_ax [4];

  function automatic int res_of(input int j);
    return (j == 0) ? 0 : j - 1;
  endfunction

  function automatic int trial_of(input int j, input int b);
    int r;
    r = res_of(j);
    return (r & ~((1 << (b + 1)) - 1) & 63) | (1 << b);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_p = 0; m_tick = 0; m_pend = 0; m_done = 0; m_dac = 0; m_sel = 0;
    for (int i = 0; i < 4; i++) m_ax[i] = 0;
  endtask

  task automatic model_step();
    bit ab, wr;
    int a, q;
    ab = snden || !enable;
    wr = (m_tick == PER - 1);
    m_tick = wr ? 0 : m_tick + 1;
    m_done = 0;
    if (!m_busy) begin
      m_dac = cpu_dac;
      m_sel = {cpu_selb, cpu_sela};
      if (m_pend && !ab) begin m_busy = 1; m_p = 0; m_pend = 0; end
    end else if (ab) begin
      m_busy = 0;
    end else begin
      a = m_p / AXC;
      q = m_p % AXC;
      if (q == AXC - 1) begin
        m_ax[a] = res_of(joy[a]);
        if (a == 3) begin m_done = 1; m_busy = 0; end
        else m_p++;
      end else begin
        if (q % BITC == 0) begin m_dac = trial_of(joy[a], 5 - q / BITC); m_sel = a; end
        m_p++;
      end
    end
    if (wr) m_pend = 1;
  endtask

  task automatic compare_all();
    check("busy", busy, m_busy);
    check("scan_done", scan_done, m_done);
    check("dac_out", dac_out, m_dac);
    check("sel", {selb_out, sela_out}, m_sel);
    check("axes", {axis3, axis2, axis1, axis0},
          {m_ax[3][5:0], m_ax[2][5:0], m_ax[1][5:0], m_ax[0][5:0]});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dac"}, dac_out, 0);
    check({tag, "_sel"}, {selb_out, sela_out}, 0);
    check({tag, "_axes"}, {axis3, axis2, axis1, axis0}, 0);
    check({tag, "_done"}, scan_done, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic       en, snd;
    logic [5:0] dac;
    logic [1:0] sel;
    logic [5:0] e_dac;
    logic [1:0] e_sel;
    logic       e_busy;
  } pt_vec_t;

  pt_vec_t tbl [5];
  int trials [6];
  int ndone, nbusy;

  initial begin
    tbl[0] = '{en: 1'b0, snd: 1'b0, dac: 6'h15, sel: 2'b10, e_dac: 6'h15, e_sel: 2'b10, e_busy: 1'b0};
    tbl[1] = '{en: 1'b0, snd: 1'b0, dac: 6'h3F, sel: 2'b11, e_dac: 6'h3F, e_sel: 2'b11, e_busy: 1'b0};
    tbl[2] = '{en: 1'b0, snd: 1'b1, dac: 6'h00, sel: 2'b01, e_dac: 6'h00, e_sel: 2'b01, e_busy: 1'b0};
    tbl[3] = '{en: 1'b1, snd: 1'b1, dac: 6'h07, sel: 2'b01, e_dac: 6'h07, e_sel: 2'b01, e_busy: 1'b0};
    tbl[4] = '{en: 1'b0, snd: 1'b0, dac: 6'h2A, sel: 2'b00, e_dac: 6'h2A, e_sel: 2'b00, e_busy: 1'b0};
    trials = '{6'h20, 6'h30, 6'h28, 6'h2C, 6'h2A, 6'h29};

    reset_n = 1'b0; enable = 1'b0; snden = 1'b0; cpu_dac = '0;
    cpu_sela = 1'b0; cpu_selb = 1'b0;
    for (int i = 0; i < 4; i++) joy[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset_n = 1'b1;
    model_reset();

    // Pass-through vectors, each checked one cycle after being applied.
    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en; snden = tbl[i].snd; cpu_dac = tbl[i].dac;
      {cpu_selb, cpu_sela} = tbl[i].sel;
      cyc();
      check($sformatf("pt%0d_dac", i), dac_out, tbl[i].e_dac);
      check($sformatf("pt%0d_sel", i), {selb_out, sela_out}, tbl[i].e_sel);
      check($sformatf("pt%0d_busy", i), busy, tbl[i].e_busy);
    end
    enable = 1'b0; snden = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 3 * PER; i++) begin cyc(); nbusy += busy; end
    check("disabled_never_busy", nbusy, 0);

    // Full scan with the reference joystick set and trial sequence on axis0.
    joy[0] = 6'h2A; joy[1] = 6'h00; joy[2] = 6'h3F; joy[3] = 6'h01;
    enable = 1'b1;
    cyc();
    check("scan_start_busy", busy, 1);
    ndone = 0;
    for (int i = 1; i <= 4 * AXC; i++) begin
      cyc();
      ndone += scan_done;
      if (i < BITC * 6 && (i % BITC) == 1)
        check($sformatf("trial%0d", i / BITC), dac_out, trials[i / BITC]);
    end
    check("scan_axes", {axis3, axis2, axis1, axis0}, {6'h00, 6'h3E, 6'h00, 6'h29});
    check("scan_done_at_end", scan_done, 1);
    check("scan_done_count", ndone, 1);
    enable = 1'b0;
    cyc();
    check("scan_end_busy", busy, 0);

    // Abort by snden in the middle of axis2.
    joy[0] = 6'h10; joy[1] = 6'h20; joy[2] = 6'h30; joy[3] = 6'h05;
    enable = 1'b1; cpu_dac = 6'h33; {cpu_selb, cpu_sela} = 2'b01;
    cyc();
    check("abort_start_busy", busy, 1);
    ndone = 0;
    for (int i = 0; i < 2 * AXC + 7; i++) begin cyc(); ndone += scan_done; end
    snden = 1'b1;
    cyc();
    check("abort_busy_falls", busy, 0);
    cyc();
    check("abort_dac_passthru", dac_out, 6'h33);
    check("abort_sel_passthru", {selb_out, sela_out}, 2'b01);
    check("abort_axes", {axis3, axis2, axis1, axis0}, {6'h00, 6'h3E, 6'h1F, 6'h0F});
    check("abort_no_done", ndone + scan_done, 0);

    // snden held high for 100 cycles: no scan, then exactly one start as it falls.
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin cyc(); nbusy += busy; end
    check("snden_hold_idle", nbusy, 0);
    snden = 1'b0;
    cyc();
    check("snden_fall_start", busy, 1);

    // Reset mid-WAIT of axis1.
    for (int i = 0; i < AXC + 2; i++) cyc();
    reset_n = 1'b0;
    #2;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if (!m_busy && $urandom_range(0, 19) == 0)
        for (int k = 0; k < 4; k++)
          case ($urandom_range(0, 3))
            0:       joy[k] = 6'h00;
            1:       joy[k] = 6'h3F;
            default: joy[k] = 6'($urandom);
          endcase
      enable   = ($urandom_range(0, 99) != 0);
      snden    = ($urandom_range(0, 79) == 0);
      cpu_dac  = 6'($urandom);
      cpu_sela = 1'($urandom);
      cpu_selb = 1'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
